pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: fetch/decode pipeline stage buffer with flush.
// DEPTH=1 acts as a plain stage register, DEPTH=2 as a two-entry skid buffer.
// Optional statistics counters are enabled by defining PIPE_STAGE_BUF_STATS_EN.
module pipe_stage_buf #(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef PIPE_STAGE_BUF_STATS_EN
  ,
  output logic [STAT_W-1:0]  stall_cnt,
  output logic [STAT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               push, pop;

  // A single-entry stage must accept a new entry in the same cycle the head drains.
  assign in_ready  = (DEPTH == 32'd1) ? (!out_valid_q || out_ready) : in_ready_q;
  assign out_valid = out_valid_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid_q && out_ready;

  // Empty stage presents a NOP bubble.
  assign out_pc    = out_valid_q ? head_pc_q    : '0;
  assign out_instr = out_valid_q ? head_instr_q : '0;

  // Occupancy state register and payload storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      head_pc_q    <= '0;
      head_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Next-state, payload movement and registered handshake outputs.
  always_comb begin
    state_d      = state_q;
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (push) begin
            head_pc_d    = in_pc;
            head_instr_d = in_instr;
            state_d      = S_ONE;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_pc_d    = in_pc;
            head_instr_d = in_instr;
          end else if (push && (DEPTH == 32'd2)) begin
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
            state_d      = S_TWO;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            head_pc_d    = skid_pc_q;
            head_instr_d = skid_instr_q;
            state_d      = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != S_TWO);
    out_valid_d = (state_d != S_EMPTY);
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating stall and flush event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
    if (flush && out_valid_q && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + STAT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (DEPTH=2 main instance, DEPTH=1 side instance).
module tb_pipe_stage_buf;

  localparam int unsigned PC_W    = 12;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned STAT_W  = 4;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               in_ready1;
  logic               out_valid1;
  logic [PC_W-1:0]    out_pc1;
  logic [INSTR_W-1:0] out_instr1;
`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [STAT_W-1:0]  stall_cnt, flush_cnt;
  logic [STAT_W-1:0]  stall_cnt1, flush_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(2), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
`ifdef PIPE_STAGE_BUF_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  pipe_stage_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(1), .STAT_W(STAT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid1),
    .out_ready(out_ready), .out_pc(out_pc1), .out_instr(out_instr1)
`ifdef PIPE_STAGE_BUF_STATS_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, '0, '0);
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

    // Stream one instruction through.
    rst_n = 1'b1; out_ready = 1'b1;
    offer(1'b1, 12'h004, 32'h20080005);
    chk("stream_in_ready_pre", 64'(in_ready), 64'd1);
    tick();
    chk("stream_out_valid", 64'(out_valid), 64'd1);
    chk("stream_out_instr", 64'(out_instr), 64'h20080005);
    chk("stream_out_pc", 64'(out_pc), 64'h004);
    chk("stream_in_ready", 64'(in_ready), 64'd1);
    offer(1'b0, '0, '0);
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_instr", 64'(out_instr), 64'd0);

    // Skid fill then drain in order.
    out_ready = 1'b0;
    offer(1'b1, 12'h010, 32'h11111111);
    tick();
    chk("skid_one_instr", 64'(out_instr), 64'h11111111);
    chk("skid_one_ready", 64'(in_ready), 64'd1);
    offer(1'b1, 12'h014, 32'h22222222);
    tick();
    chk("skid_two_ready", 64'(in_ready), 64'd0);
    chk("skid_two_instr", 64'(out_instr), 64'h11111111);
    chk("skid_two_pc", 64'(out_pc), 64'h010);
    offer(1'b0, '0, '0);
    tick();
    chk("skid_hold_instr", 64'(out_instr), 64'h11111111);
    out_ready = 1'b1;
    tick();
    chk("skid_pop_b_instr", 64'(out_instr), 64'h22222222);
    chk("skid_pop_b_pc", 64'(out_pc), 64'h014);
    chk("skid_pop_ready", 64'(in_ready), 64'd1);
    tick();
    chk("skid_empty_valid", 64'(out_valid), 64'd0);
    chk("skid_empty_instr", 64'(out_instr), 64'd0);
    chk("skid_empty_pc", 64'(out_pc), 64'd0);
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("skid_stall_cnt", 64'(stall_cnt), 64'd2);
`endif

    // Flush with simultaneous push while full.
    out_ready = 1'b0;
    offer(1'b1, 12'h010, 32'h11111111);
    tick();
    offer(1'b1, 12'h014, 32'h22222222);
    tick();
    flush = 1'b1;
    offer(1'b1, 12'h018, 32'h33333333);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_instr", 64'(out_instr), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("flush_flush_cnt", 64'(flush_cnt), 64'd1);
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd4);
`endif
    offer(1'b0, '0, '0);
    tick();
    chk("flush_empty_ok", 64'(out_valid), 64'd0);
    tick();
    chk("flush_c_never_out", 64'(out_valid), 64'd0);
    // Flush while empty.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty_valid", 64'(out_valid), 64'd0);
    chk("flush_empty_ready", 64'(in_ready), 64'd1);
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("flush_empty_cnt", 64'(flush_cnt), 64'd1);
`endif

    // Push and pop together in ONE.
    out_ready = 1'b1;
    offer(1'b1, 12'h010, 32'h11111111);
    tick();
    chk("pp_head_a", 64'(out_instr), 64'h11111111);
    offer(1'b1, 12'h01c, 32'h44444444);
    tick();
    chk("pp_valid", 64'(out_valid), 64'd1);
    chk("pp_instr_d", 64'(out_instr), 64'h44444444);
    chk("pp_pc_d", 64'(out_pc), 64'h01c);
    chk("pp_ready", 64'(in_ready), 64'd1);
    offer(1'b0, '0, '0);
    tick();
    chk("pp_drain", 64'(out_valid), 64'd0);

    // Reset while full.
    out_ready = 1'b0;
    offer(1'b1, 12'h010, 32'h11111111);
    tick();
    offer(1'b1, 12'h014, 32'h22222222);
    tick();
    chk("mid_full_ready", 64'(in_ready), 64'd0);
    offer(1'b0, '0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_instr", 64'(out_instr), 64'd0);
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
    chk("mid_rst_flush", 64'(flush_cnt), 64'd0);
`endif

    // Long stall: payload stable, stall counter saturates.
    offer(1'b1, 12'h020, 32'h55555555);
    tick();
    offer(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_hold_instr", 64'(out_instr), 64'h55555555);
    chk("stall_hold_pc", 64'(out_pc), 64'h020);
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("stall_sat", 64'(stall_cnt), 64'd15);
`endif
    out_ready = 1'b1;
    tick();
    chk("stall_release_valid", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_BUF_STATS_EN
    chk("stall_no_wrap", 64'(stall_cnt), 64'd15);
`endif

    // DEPTH=1 instance: combinational ready, replace-on-pop.
    rst_n = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("d1_rst_ready", 64'(in_ready1), 64'd1);
    offer(1'b1, 12'h030, 32'h66666666);
    tick();
    chk("d1_valid", 64'(out_valid1), 64'd1);
    chk("d1_instr_x", 64'(out_instr1), 64'h66666666);
    chk("d1_full_ready", 64'(in_ready1), 64'd0);
    offer(1'b1, 12'h034, 32'h77777777);
    tick();
    chk("d1_hold_x", 64'(out_instr1), 64'h66666666);
    out_ready = 1'b1;
    #1;
    chk("d1_comb_ready", 64'(in_ready1), 64'd1);
    tick();
    chk("d1_instr_y", 64'(out_instr1), 64'h77777777);
    chk("d1_pc_y", 64'(out_pc1), 64'h034);
    offer(1'b0, '0, '0);
    tick();
    chk("d1_empty_valid", 64'(out_valid1), 64'd0);
    chk("d1_empty_instr", 64'(out_instr1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
